// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and helpers for the RV32I instruction fetch stage.
//   fetch_state_e : fetch controller states (S_HALT exists only when the
//                   FETCH_ILLEGAL_HALT_EN macro is defined).
//   fetch_entry_t : one buffered instruction word plus the PC it came from.
//   ILEN, PC_STEP : instruction width and sequential PC increment.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int          ILEN    = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1
`ifdef FETCH_ILLEGAL_HALT_EN
        ,
        S_HALT  = 2'd2
`endif
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [ILEN-1:0] pc;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    // RV32I (non-compressed) encodings always carry 2'b11 in bits [1:0].
    function automatic logic is_legal_opcode(input logic [31:0] word);
        return (word[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/fetch_chk.sv
// -----------------------------------------------------------------------------
// fetch_chk
// Protocol checker for the fetch stage instruction buffer. The request credit
// rule means a response always has a free slot, so a push into a full buffer
// or a pop from an empty one indicates a design error.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_push, i_pop    : effective buffer push / pop
//   i_full, i_empty  : buffer occupancy flags
// -----------------------------------------------------------------------------
module fetch_chk (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  logic i_pop,
    input  logic i_full,
    input  logic i_empty
);

    a_no_push_when_full: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) !(i_push && i_full)
    );

    a_no_pop_when_empty: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) !(i_pop && i_empty)
    );

endmodule

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// In-order synchronous FIFO of fetch_entry_t with a flush that overrides
// push and pop in the same cycle.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : empty the FIFO (any push in the same cycle is dropped)
//   i_push         : write i_push_data at the tail
//   i_pop          : advance the head (caller guarantees not empty)
//   o_head         : head entry, read straight from the storage registers
//   o_full/o_empty : occupancy flags
//   o_count        : number of valid entries
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_data,
    input  logic                     i_pop,
    output fetch_entry_t             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q,  count_d;
    logic           do_push_s;
    logic           do_pop_s;

    assign do_push_s = i_push && !i_flush;
    assign do_pop_s  = i_pop  && !i_flush;

    // Next-state for storage, pointers and occupancy count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push_s && (wr_ptr_q == AW'(i))) begin
                mem_d[i] = i_push_data;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end

        if (i_flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            wr_ptr_d = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_d = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{instr: 32'h0000_0000, pc: 32'h0000_0000};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_empty = (count_q == {CW{1'b0}});
    assign o_full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// RV32I fetch stage. Issues word-aligned requests to instruction memory using
// req/gnt with in-order rvalid responses, buffers returned words in an
// in-order FIFO and hands them to the decoder with a valid/ready handshake.
// Redirects from execute flush the buffer and discard stale responses.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   o_imem_req, o_imem_addr         memory request and word-aligned address
//   i_imem_gnt                      request accepted this cycle
//   i_imem_rvalid, i_imem_rdata     in-order response
//   i_redirect_valid, i_redirect_pc redirect from execute (highest priority)
//   o_instr_valid, o_instr,
//   o_instr_pc, i_instr_ready       decoder handshake
//   o_fetch_halted                  only with FETCH_ILLEGAL_HALT_EN defined
//
// Optional feature macro: FETCH_ILLEGAL_HALT_EN. When defined, a buffered
// word whose bits [1:0] are not 2'b11 halts request issue until the next
// redirect; the word itself is still delivered.
// -----------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_instr_ready
`ifdef FETCH_ILLEGAL_HALT_EN
    ,
    output logic        o_fetch_halted
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    // PC of the next response that will be kept (stale ones do not advance it).
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] discard_q, discard_d;

    logic          req_s;
    logic          grant_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   occupancy_s;
    fetch_entry_t  push_entry_s;
    fetch_entry_t  head_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;

    // Reserved slots = words in flight plus words already buffered.
    assign occupancy_s = 32'(outstanding_q) + 32'(fifo_count_s);

    // Request issue: only while fetching, with a guaranteed buffer slot and
    // a free outstanding credit; a redirect suppresses the stale address.
    always_comb begin
        req_s = 1'b0;
        if ((state_q == S_FETCH) &&
            (occupancy_s < 32'(FIFO_DEPTH)) &&
            (32'(outstanding_q) < 32'(MAX_OUTSTANDING)) &&
            !i_redirect_valid) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    assign grant_s = req_s && i_imem_gnt;
    assign drop_s  = i_imem_rvalid && (discard_q != {OW{1'b0}});
    // A word arriving with a redirect belongs to the old path and is dropped.
    assign push_s  = i_imem_rvalid && (discard_q == {OW{1'b0}}) && !i_redirect_valid;
    assign pop_s   = !fifo_empty_s && i_instr_ready;

    assign push_entry_s = '{instr: i_imem_rdata, pc: rsp_pc_q};

    // PC, response PC, outstanding and discard bookkeeping.
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + OW'(grant_s) - OW'(i_imem_rvalid);
        if (i_redirect_valid) begin
            pc_d      = align_pc(i_redirect_pc);
            rsp_pc_d  = align_pc(i_redirect_pc);
            // Everything still in flight after this edge is stale, including
            // a request granted in this very cycle.
            discard_d = outstanding_q - OW'(i_imem_rvalid) + OW'(grant_s);
        end else begin
            pc_d      = grant_s ? pc_q + PC_STEP : pc_q;
            rsp_pc_d  = push_s  ? rsp_pc_q + PC_STEP : rsp_pc_q;
            discard_d = drop_s  ? discard_q - OW'(1'b1) : discard_q;
        end
    end

    // Fetch controller next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
`ifdef FETCH_ILLEGAL_HALT_EN
                if (push_s && !is_legal_opcode(i_imem_rdata)) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
`else
                state_d = S_FETCH;
`endif
            end
`ifdef FETCH_ILLEGAL_HALT_EN
            S_HALT: begin
                if (i_redirect_valid) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
`endif
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // Controller and bookkeeping registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= align_pc(RESET_PC);
            rsp_pc_q      <= align_pc(RESET_PC);
            outstanding_q <= {OW{1'b0}};
            discard_q     <= {OW{1'b0}};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_redirect_valid),
        .i_push      (push_s),
        .i_push_data (push_entry_s),
        .i_pop       (pop_s),
        .o_head      (head_s),
        .o_full      (fifo_full_s),
        .o_empty     (fifo_empty_s),
        .o_count     (fifo_count_s)
    );

    fetch_chk u_chk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push_s),
        .i_pop   (pop_s),
        .i_full  (fifo_full_s),
        .i_empty (fifo_empty_s)
    );

    assign o_imem_req    = req_s;
    assign o_imem_addr   = pc_q;
    assign o_instr_valid = !fifo_empty_s;
    assign o_instr       = head_s.instr;
    assign o_instr_pc    = head_s.pc;

`ifdef FETCH_ILLEGAL_HALT_EN
    assign o_fetch_halted = (state_q == S_HALT);
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- RV32I fetch stage. Sits directly upstream of the decoder and supplies it with 32-bit instruction words.
- Holds the PC and issues word-aligned requests to instruction memory using a request/grant plus response-valid protocol.
- Buffers returned words in an in-order FIFO and presents them downstream with a valid/ready handshake.
- Accepts redirects (branch/jump) from execute, which flush the FIFO and discard stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, at least 2.
- MAX_OUTSTANDING, 2, maximum memory requests in flight; must be no greater than FIFO_DEPTH.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- o_imem_req  out  1  memory request valid.
- o_imem_addr  out  32  request address, always word-aligned.
- i_imem_gnt  in  1  request accepted this cycle.
- i_imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant.
- i_imem_rdata  in  32  response word.
- i_redirect_valid  in  1  redirect the PC this cycle.
- i_redirect_pc  in  32  redirect target.
- o_instr_valid  out  1  FIFO head valid toward the decoder.
- o_instr  out  32  instruction word; feeds the decoder's i_instruction.
- o_instr_pc  out  32  PC of o_instr.
- i_instr_ready  in  1  decoder consumes the head this cycle.

Behaviour:
- Reset (asynchronous, active-low):
  - pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0; FSM = S_BOOT.
  - o_imem_req = 0, o_imem_addr = RESET_PC, o_instr_valid = 0, o_instr = 0, o_instr_pc = 0.
- FSM states:
  - S_BOOT: one idle cycle after reset release, then unconditionally S_FETCH.
  - S_FETCH: normal operation.
  - S_HALT: entered only through the optional feature; exits to S_FETCH only on redirect.
- Request issue:
  - o_imem_req = (state == S_FETCH) && (outstanding + fifo_count < FIFO_DEPTH) && (outstanding < MAX_OUTSTANDING) && !i_redirect_valid.
  - o_imem_addr = pc (combinational from the register).
  - On req && gnt: pc += 4 (wraps modulo 2^32), outstanding += 1.
  - This credit rule guarantees every response has a FIFO slot; no backpressure toward memory exists.
- Response handling:
  - On i_imem_rvalid: outstanding -= 1.
  - If discard > 0, drop the word and decrement discard.
  - Otherwise push {word, pc_of_request}. Request PCs are tracked in a small in-order queue or derived from a response PC counter.
- Output:
  - o_instr_valid = !fifo_empty; o_instr and o_instr_pc are driven from the head register.
  - The head pops on o_instr_valid && i_instr_ready.
  - Zero-cycle bypass is not permitted: minimum rvalid-to-o_instr_valid latency is 1 cycle.
- Redirect (highest priority):
  - FIFO is flushed the same cycle, so o_instr_valid = 0 next cycle.
  - pc = {i_redirect_pc[31:2], 2'b00}.
  - discard = outstanding − (rvalid this cycle ? 1 : 0) + (req && gnt this cycle ? 1 : 0). A request granted that cycle is still counted as stale.
  - A pop on the redirect cycle is still honoured for the consumer.
- Simultaneous events:
  - Push and pop together leave the count unchanged.
  - A redirect together with a push means the push is dropped.
- Boundaries:
  - FIFO full means no request is issued; pushes on a full FIFO are impossible by construction and asserted against.
  - Back-to-back redirects: the second one wins and discard is recomputed.

Optional Feature:
- Macro: FETCH_ILLEGAL_HALT_EN.
- Defined:
  - A pushed word with opcode bits [1:0] != 2'b11 moves the FSM to S_HALT.
  - In S_HALT no new requests are issued; outstanding responses are still absorbed.
  - The offending word is still delivered; o_fetch_halted (out, 1) asserts.
- Undefined:
  - Port and S_HALT are absent; all words pass through unchecked.

Decomposition:
- Package fetch_pkg:
  - fetch_state_e {S_BOOT, S_FETCH, S_HALT}.
  - typedef fetch_entry_t {logic [31:0] instr; logic [31:0] pc;}.
  - ILEN = 32, PC_STEP = 4.
- One sub-module, fetch_fifo: a parameterised synchronous FIFO with flush, push, pop, full, empty and count.

Test Plan:
- Reset release with memory granting every cycle at 1-cycle latency and i_instr_ready = 1 -> addresses 0x0, 0x4, 0x8… issued from cycle 2; o_instr_pc follows in order; o_instr matches memory contents.
- i_instr_ready = 0 held for 10 cycles -> exactly FIFO_DEPTH (4) words buffered; o_imem_req deasserts; no word lost on release.
- Redirect to 0x0000_0103 while 2 requests are outstanding -> next address 0x100; the 2 stale responses are discarded; first delivered o_instr_pc = 0x100.
- Redirect in the same cycle as rvalid and a grant -> discard count is correct; no stale word appears at the output.
- PC at 0xFFFF_FFFC -> next request address 0x0000_0000.
- With FETCH_ILLEGAL_HALT_EN: word 32'h0000_0000 returned -> delivered, o_fetch_halted = 1, requests stop; redirect to 0x40 resumes fetch.
